// File: rtl/pulse_measure.sv
// Measures high and low width of each complete period of a sampled waveform,
// bounded by consecutive rising edges, with a one-cycle valid strobe per period.
module pulse_measure #(
  parameter int CW          = 16,
  parameter int NW          = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          enable,
  input  logic          signal,
  output logic [CW-1:0] high_width,
  output logic [CW-1:0] low_width,
  output logic [NW-1:0] pulse_count,
  output logic          valid,
  output logic          overflow,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  localparam logic [CW-1:0] CMAX = '1;

  logic sig_s;
  logic sig_d_q;
  logic rise;
  logic fall;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign sig_s = signal;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;
      logic [SYNC_STAGES:0]   shift_w;
      assign shift_w = {sync_q, signal};
      always_ff @(posedge clock) begin
        if (reset) sync_q <= '0;
        else       sync_q <= shift_w[SYNC_STAGES-1:0];
      end
      assign sig_s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // Edge flop keeps sampling while disabled so a re-enable mid-high sees no rise.
  always_ff @(posedge clock) begin
    if (reset) sig_d_q <= 1'b0;
    else       sig_d_q <= sig_s;
  end

  assign rise = sig_s & ~sig_d_q;
  assign fall = ~sig_s & sig_d_q;

  state_t        state_q, state_d;
  logic [CW-1:0] hi_cnt_q, hi_cnt_d;
  logic [CW-1:0] lo_cnt_q, lo_cnt_d;
  logic [CW-1:0] hi_lat_q, hi_lat_d;
  logic          ovf_int_q, ovf_int_d;
  logic [CW-1:0] hw_q, hw_d;
  logic [CW-1:0] lw_q, lw_d;
  logic [NW-1:0] pc_q, pc_d;
  logic          valid_q, valid_d;
  logic          ovf_q, ovf_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      hi_cnt_q  <= '0;
      lo_cnt_q  <= '0;
      hi_lat_q  <= '0;
      ovf_int_q <= 1'b0;
      hw_q      <= '0;
      lw_q      <= '0;
      pc_q      <= '0;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      hi_cnt_q  <= hi_cnt_d;
      lo_cnt_q  <= lo_cnt_d;
      hi_lat_q  <= hi_lat_d;
      ovf_int_q <= ovf_int_d;
      hw_q      <= hw_d;
      lw_q      <= lw_d;
      pc_q      <= pc_d;
      valid_q   <= valid_d;
      ovf_q     <= ovf_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    hi_cnt_d  = hi_cnt_q;
    lo_cnt_d  = lo_cnt_q;
    hi_lat_d  = hi_lat_q;
    ovf_int_d = ovf_int_q;
    hw_d      = hw_q;
    lw_d      = lw_q;
    pc_d      = pc_q;
    ovf_d     = ovf_q;
    valid_d   = 1'b0;
    if (!enable) begin
      state_d   = IDLE;
      hi_cnt_d  = '0;
      lo_cnt_d  = '0;
      ovf_int_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rise) begin
            state_d   = HIGH;
            hi_cnt_d  = CW'(1);
            ovf_int_d = 1'b0;
          end
        end
        HIGH: begin
          if (fall) begin
            state_d  = LOW;
            hi_lat_d = hi_cnt_q;
            lo_cnt_d = CW'(1);
          end else if (sig_s) begin
            if (hi_cnt_q == CMAX) ovf_int_d = 1'b1;
            else                  hi_cnt_d  = hi_cnt_q + 1'b1;
          end
        end
        LOW: begin
          if (rise) begin
            hw_d      = hi_lat_q;
            lw_d      = lo_cnt_q;
            ovf_d     = ovf_int_q;
            valid_d   = 1'b1;
            pc_d      = pc_q + 1'b1;
            state_d   = HIGH;
            hi_cnt_d  = CW'(1);
            ovf_int_d = 1'b0;
          end else if (!sig_s) begin
            if (lo_cnt_q == CMAX) ovf_int_d = 1'b1;
            else                  lo_cnt_d  = lo_cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign high_width  = hw_q;
  assign low_width   = lw_q;
  assign pulse_count = pc_q;
  assign valid       = valid_q;
  assign overflow    = ovf_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: doc/pulse_measure.md
Name: pulse_measure

Overview:
- Receive-side counterpart to the testbench pulse generators: samples a single-bit waveform on `clock` and measures each complete period.
- A period is high time plus low time, bounded by consecutive rising edges; both are counted in clock cycles.
- Reports high width, low width and a running pulse count, with a one-cycle valid strobe per completed period.
- Used by benches and self-checking logic to confirm generated duty cycles and periods without waveform inspection.

Parameters:
- CW, 16: width of the high/low width counters and outputs (saturating).
- NW, 8: width of the pulse counter (wrapping).
- SYNC_STAGES, 2: synchronizer flops on `signal`, legal values 0 to 3; 0 means `signal` is already synchronous.

Ports:
- clock  input  1  sole clock, all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  measurement enable; low forces IDLE.
- signal  input  1  waveform under measurement.
- high_width  output  CW  high samples in the last completed period.
- low_width  output  CW  low samples in the last completed period.
- pulse_count  output  NW  number of completed periods since reset.
- valid  output  1  one-cycle strobe; new high_width/low_width/overflow present.
- overflow  output  1  a counter saturated during the reported period.
- busy  output  1  FSM not in IDLE.

Behaviour:
- Reset (posedge with reset=1):
  - All outputs go to 0.
  - FSM goes to IDLE; internal hi_cnt, lo_cnt, sync and edge flops cleared.
  - Reset has priority over enable and signal.
- Sampling and edge detection:
  - sig_s is `signal` after SYNC_STAGES flops; sig_d is sig_s delayed one cycle.
  - rise = sig_s & ~sig_d; fall = ~sig_s & sig_d.
- FSM states:
  - IDLE: busy=0, ignores level. On rise → HIGH, hi_cnt=1, ovf_int=0. A signal already high at enable is not measured until its next rise.
  - HIGH: sig_s=1 → hi_cnt+1, saturating at 2^CW-1; saturation sets ovf_int. On fall → LOW, hi_lat=hi_cnt, lo_cnt=1.
  - LOW: sig_s=0 → lo_cnt+1, saturating, sets ovf_int. On rise, at the same edge:
    - Register high_width=hi_lat, low_width=lo_cnt, overflow=ovf_int.
    - valid=1 and pulse_count+1 (wraps mod 2^NW).
    - Go to HIGH with hi_cnt=1, ovf_int=0.
- Output timing:
  - valid is registered: high for exactly the one cycle after the measuring posedge.
  - Latency from `signal` rising before posedge k to valid high is posedge k+SYNC_STAGES.
  - high_width, low_width and overflow hold their values until the next valid. pulse_count holds between increments.
- Minimum pulse: 1-cycle high / 1-cycle low is measured correctly (widths 1,1; valid every 2 cycles).
- enable=0 at any posedge:
  - FSM goes to IDLE; hi_cnt, lo_cnt, ovf_int cleared; no valid.
  - Outputs and pulse_count hold.
  - Sync and edge flops keep sampling, so re-enable during a high level does not produce a false rise.
- Reset mid-period: the partial measurement is discarded and no valid is issued.
- Simultaneous rise and enable deassert: enable wins, no valid.
- Saturated counters stay at 2^CW-1 until the next rise or fall reload.

Test Plan:
- Reset for 2 cycles with signal toggling → all outputs 0, busy=0; no valid for 3 cycles after reset release while signal is held low.
- SYNC_STAGES=0, signal 3 high / 5 low repeated 4 times from low → 3 valids spaced 8 cycles apart, each with high_width=3, low_width=5, overflow=0; pulse_count ends at 3; first valid at the second rise.
- signal high when enable rises, falls after 6 cycles, then 2 high / 2 low → first partial high ignored; first report high_width=2, low_width=2.
- CW=4, signal high 20 cycles then low 2 cycles then rise → high_width=15, low_width=2, overflow=1; next 4/4 period reports overflow=0.
- enable dropped 2 cycles into a LOW phase, restored next cycle, then 3/3 periods → no valid for the aborted period; busy=0 during the drop; subsequent reports 3/3; pulse_count unchanged by the abort.
- NW=2, 5 periods of 1 high / 1 low → widths 1,1 each valid; pulse_count sequence 1,2,3,0,1.
